// File: rtl/conv_job_arbiter_if.sv
// rtl/conv_job_arbiter_if.sv - request, engine and response channels of the conv job arbiter
interface conv_job_arbiter_if #(
  parameter int QI        = 4,
  parameter int QF        = 4,
  parameter int NUM_ELEMS = 3
) ();
  localparam int W  = QI + QF;
  localparam int KW = 6 * W;
  localparam int SW = 2 * W * NUM_ELEMS;
  localparam int CW = 2 * W * (NUM_ELEMS + 2);

  logic          req0_valid;
  logic          req0_ready;
  logic [KW-1:0] req0_kernel;
  logic [SW-1:0] req0_signal;
  logic          req1_valid;
  logic          req1_ready;
  logic [KW-1:0] req1_kernel;
  logic [SW-1:0] req1_signal;

  logic          eng_en;
  logic [KW-1:0] eng_kernel;
  logic [SW-1:0] eng_signal;
  logic [CW-1:0] eng_conv;
  logic          eng_overflow;
  logic          eng_done;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [CW-1:0] rsp_conv;
  logic          rsp_overflow;
  logic          rsp_timeout;
  logic          busy;

  // Job sources, engine and response consumer side
  modport master (
    output req0_valid, req0_kernel, req0_signal,
    output req1_valid, req1_kernel, req1_signal,
    output eng_conv, eng_overflow, eng_done, rsp_ready,
    input  req0_ready, req1_ready, eng_en, eng_kernel, eng_signal,
    input  rsp_valid, rsp_id, rsp_conv, rsp_overflow, rsp_timeout, busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_kernel, req0_signal,
    input  req1_valid, req1_kernel, req1_signal,
    input  eng_conv, eng_overflow, eng_done, rsp_ready,
    output req0_ready, req1_ready, eng_en, eng_kernel, eng_signal,
    output rsp_valid, rsp_id, rsp_conv, rsp_overflow, rsp_timeout, busy
  );
endinterface

// File: rtl/conv_job_arbiter.sv
// rtl/conv_job_arbiter.sv - round-robin sharing of one conv_complex engine between two requesters (optional watchdog: CONV_TIMEOUT_EN)
module conv_job_arbiter #(
  parameter int QI             = 4,
  parameter int QF             = 4,
  parameter int NUM_ELEMS      = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  conv_job_arbiter_if.slave bus
);
  localparam int W  = QI + QF;
  localparam int KW = 6 * W;
  localparam int SW = 2 * W * NUM_ELEMS;
  localparam int CW = 2 * W * (NUM_ELEMS + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          last_grant;
  logic          grant1;
  logic          accept0, accept1, accept;
  logic          abort;
  logic [KW-1:0] kernel_q;
  logic [SW-1:0] signal_q;
  logic [CW-1:0] conv_q;
  logic          id_q;
  logic          ovf_q;

  // State register; reset discards any job in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Grant, next state and status outputs; requester 1 wins when alone or when 0 was served last
  always_comb begin
    state_d       = state_q;
    grant1        = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    accept0       = (state_q == IDLE) & bus.req0_valid & ~grant1;
    accept1       = (state_q == IDLE) & grant1;
    accept        = accept0 | accept1;
    bus.req0_ready = accept0;
    bus.req1_ready = accept1;
    bus.eng_en    = (state_q == RUN);
    bus.rsp_valid = (state_q == RESP);
    bus.busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (bus.eng_done || abort) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef CONV_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] cnt_q;
  logic            timeout_q;

  // Watchdog: counts RUN cycles without done; abort on the edge it would reach the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt_q <= '0;
    else if (accept)                           cnt_q <= '0;
    else if (state_q == RUN && !bus.eng_done)  cnt_q <= cnt_q + 1'b1;
  end

  assign abort = (state_q == RUN) && !bus.eng_done && (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  // Timeout flag follows the response it belongs to; a real done always wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    timeout_q <= 1'b0;
    else if (state_q == RUN && bus.eng_done)     timeout_q <= 1'b0;
    else if (abort)                              timeout_q <= 1'b1;
    else if (state_q == RESP && bus.rsp_ready)   timeout_q <= 1'b0;
  end

  assign bus.rsp_timeout = timeout_q;
`else
  assign abort = 1'b0;
  // Without the watchdog the limit has no effect; the flag is constant low
  assign bus.rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Operand latch on accept, result capture on done (or zeroed result on abort)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      kernel_q   <= '0;
      signal_q   <= '0;
      conv_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) begin
        kernel_q   <= accept1 ? bus.req1_kernel : bus.req0_kernel;
        signal_q   <= accept1 ? bus.req1_signal : bus.req0_signal;
        id_q       <= accept1;
        last_grant <= accept1;
      end
      if (state_q == RUN && bus.eng_done) begin
        conv_q <= bus.eng_conv;
        ovf_q  <= bus.eng_overflow;
      end else if (abort) begin
        conv_q <= '0;
        ovf_q  <= 1'b0;
      end
    end
  end

  assign bus.eng_kernel   = kernel_q;
  assign bus.eng_signal   = signal_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_conv     = conv_q;
  assign bus.rsp_overflow = ovf_q;
endmodule

// File: tb/tb_conv_job_arbiter.sv
// tb/tb_conv_job_arbiter.sv - randomized self-checking bench for conv_job_arbiter
module tb_conv_job_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_job_arbiter_if #(.QI(4), .QF(4), .NUM_ELEMS(3)) bus ();
  conv_job_arbiter #(.QI(4), .QF(4), .NUM_ELEMS(3), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Job-level reference: phase 0 idle, 1 engine running, 2 response pending
  int          m_phase, m_run, m_delay;
  bit          m_last, m_id, m_ovf, m_to;
  logic [47:0] m_k, m_s;
  logic [79:0] m_conv;

  // Stimulus controls
  bit          v0, v1, rr, stale, rand_eng;
  logic [47:0] k0, s0, k1, s1;
  logic [79:0] conv_val;
  bit          ovf_val;
  int          next_delay;
  int          en_low;
  int          dut_ids[$];

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [79:0] rnd80();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic check_regs();
    check("busy", bus.busy, m_phase != 0);
    check("eng_en", bus.eng_en, m_phase == 1);
    check("rsp_valid", bus.rsp_valid, m_phase == 2);
    check("rsp_timeout", bus.rsp_timeout, (m_phase == 2) ? m_to : 1'b0);
    if (m_phase == 1) begin
      check("eng_kernel", bus.eng_kernel, m_k);
      check("eng_signal", bus.eng_signal, m_s);
    end
    if (m_phase == 2) begin
      check("rsp_id", bus.rsp_id, m_id);
      check("rsp_conv", bus.rsp_conv, m_conv);
      check("rsp_overflow", bus.rsp_overflow, m_ovf);
    end
  endtask

  // One clock: drive at negedge, check readies, advance model, check registered outputs
  task automatic step();
    bit done, acc, win;
    bus.req0_valid = v0; bus.req0_kernel = k0; bus.req0_signal = s0;
    bus.req1_valid = v1; bus.req1_kernel = k1; bus.req1_signal = s1;
    bus.rsp_ready = rr;
    if (rand_eng) begin
      conv_val = rnd80();
      ovf_val  = 1'($urandom % 2);
    end
    bus.eng_conv = conv_val;
    bus.eng_overflow = ovf_val;
    done = (m_phase == 1) ? (m_run == m_delay) : (stale && ($urandom % 2 == 1));
    bus.eng_done = done;
    #1;
    acc = (m_phase == 0) && (v0 || v1);
    win = (v0 && v1) ? !m_last : v1;
    check("req0_ready", bus.req0_ready, acc && !win);
    check("req1_ready", bus.req1_ready, acc && win);
    if (bus.rsp_valid && rr) dut_ids.push_back(int'(bus.rsp_id));
    case (m_phase)
      0: if (acc) begin
        m_phase = 1; m_id = win; m_last = win;
        m_k = win ? k1 : k0; m_s = win ? s1 : s0;
        m_run = 0; m_delay = next_delay;
      end
      1: begin
        if (done) begin
          m_phase = 2; m_conv = conv_val; m_ovf = ovf_val; m_to = 0;
        end
`ifdef CONV_TIMEOUT_EN
        else if (m_run == T - 1) begin
          m_phase = 2; m_conv = '0; m_ovf = 0; m_to = 1;
        end
`endif
        else m_run++;
      end
      default: if (rr) begin
        m_phase = 0; m_to = 0;
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    check_regs();
    if (bus.eng_en) begin
      if (en_low > 0) check("eng_en_gap", en_low >= 2, 1'b1);
      en_low = 0;
    end else begin
      en_low++;
    end
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_phase = 0; m_last = 1; m_to = 0; en_low = 2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_eng_en", bus.eng_en, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, 1'b0);
    check("rst_rsp_ovf", bus.rsp_overflow, 1'b0);
    check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("rst_rsp_conv", bus.rsp_conv, 80'h0);
    check("rst_eng_kernel", bus.eng_kernel, 48'h0);
    check("rst_eng_signal", bus.eng_signal, 48'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_phase(input int ph, input int budget, input string tag);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      step();
      n++;
    end
    check(tag, {bus.busy, bus.eng_en, bus.rsp_valid},
          (ph == 0) ? 3'b000 : (ph == 1) ? 3'b110 : 3'b101);
  endtask

  task automatic run_until_rsp(input int count, input int budget, input string tag);
    int n = 0;
    while (dut_ids.size() < count && n < budget) begin
      step();
      n++;
    end
    check(tag, dut_ids.size(), count);
  endtask

  initial begin
    v0 = 0; v1 = 0; rr = 1; stale = 0; rand_eng = 1;
    k0 = '0; s0 = '0; k1 = '0; s1 = '0; conv_val = '0; ovf_val = 0; next_delay = 2;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_kernel = '0; bus.req0_signal = '0;
    bus.req1_kernel = '0; bus.req1_signal = '0; bus.eng_conv = '0; bus.eng_overflow = 0;
    bus.eng_done = 0; bus.rsp_ready = 0;
    @(negedge clk);
    do_reset();

    // Contention straight out of reset: grant order 0,1,0,1
    dut_ids.delete();
    v0 = 1; v1 = 1; k0 = rnd48(); s0 = rnd48(); k1 = rnd48(); s1 = rnd48();
    run_until_rsp(4, 200, "contention_count");
    for (int i = 0; i < 4 && i < dut_ids.size(); i++) check("contention_id", dut_ids[i], i % 2);
    v0 = 0; v1 = 0;

    // Single directed job from requester 0
    dut_ids.delete();
    rand_eng = 0; conv_val = 80'hA5A5_A5A5_A5A5_A5A5_A55A; ovf_val = 1; next_delay = 4;
    k0 = 48'h04_20_12_F0_00_F4; s0 = 48'h11_D0_FA_14_28_FC; v0 = 1;
    run_until_phase(1, 20, "single_accept");
    v0 = 0;
    run_until_phase(2, 20, "single_resp");
    check("single_conv", bus.rsp_conv, 80'hA5A5_A5A5_A5A5_A5A5_A55A);
    check("single_id", bus.rsp_id, 1'b0);
    check("single_ovf", bus.rsp_overflow, 1'b1);
    run_until_rsp(1, 20, "single_count");
    rand_eng = 1;

    // Backpressure: response held for 10 cycles while requests are pending
    rr = 0; v1 = 1; k1 = rnd48(); s1 = rnd48(); next_delay = 3;
    run_until_phase(2, 30, "bp_resp");
    for (int i = 0; i < 10; i++) begin
      v0 = 1'($urandom % 2);
      step();
    end
    rr = 1; v0 = 0; v1 = 0;
    step();
    check("bp_idle", bus.busy, 1'b0);

    // Stale done while idle
    stale = 1;
    repeat (4) step();
    stale = 0;

    // Reset two cycles into a run, then a clean job from requester 1
    v0 = 1; next_delay = 5; k0 = rnd48(); s0 = rnd48();
    run_until_phase(1, 10, "rst_accept");
    v0 = 0;
    step();
    step();
    do_reset();
    dut_ids.delete();
    v1 = 1; k1 = rnd48(); s1 = rnd48(); next_delay = 3;
    run_until_phase(1, 10, "post_rst_accept");
    v1 = 0;
    run_until_rsp(1, 30, "post_rst_count");
    if (dut_ids.size() > 0) check("post_rst_id", dut_ids[0], 1);

`ifdef CONV_TIMEOUT_EN
    // Engine never answers: watchdog returns a zeroed, flagged response
    next_delay = 1000; v0 = 1; rr = 0;
    run_until_phase(1, 10, "to_accept");
    v0 = 0;
    run_until_phase(2, T + 4, "to_resp");
    check("to_flag", bus.rsp_timeout, 1'b1);
    check("to_conv", bus.rsp_conv, 80'h0);
    rr = 1;
    step();
    // Done on the same cycle as the limit: real result wins
    next_delay = T - 1; v1 = 1; rr = 0;
    run_until_phase(1, 10, "tie_accept");
    v1 = 0;
    run_until_phase(2, T + 4, "tie_resp");
    check("tie_flag", bus.rsp_timeout, 1'b0);
    rr = 1;
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      v0 = 1'($urandom % 2); v1 = 1'($urandom % 2);
      if ($urandom % 3 == 0) begin k0 = rnd48(); s0 = rnd48(); end
      if ($urandom % 3 == 0) begin k1 = rnd48(); s1 = rnd48(); end
      rr = ($urandom % 10) < 7;
      stale = 1'($urandom % 2);
`ifdef CONV_TIMEOUT_EN
      next_delay = $urandom_range(0, 9);
`else
      next_delay = $urandom_range(0, 6);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_job_arbiter.md
Name: conv_job_arbiter

Overview:
- Shares one conv_complex engine between two requesters.
- Round-robin arbitration picks one request at a time. Each accepted request's kernel and signal operands are latched and driven to the engine, and `eng_en` is held until the engine reports `eng_done`.
- The result and overflow flag are captured and returned on a valid/ready response channel tagged with the requester id.
- Sits between the host-side job sources and the conv_complex datapath.

Parameters:
- QI, 4, integer bits per real/imag component (Q format)
- QF, 4, fractional bits per component
- NUM_ELEMS, 3, complex samples per signal
- TIMEOUT_CYCLES, 64, cycles in RUN before watchdog abort (used only with CONV_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_kernel  in  6*(QI+QF)  3 complex taps, tap0 in LSBs
- req0_signal  in  2*(QI+QF)*NUM_ELEMS  complex samples
- req1_valid / req1_ready / req1_kernel / req1_signal  same as requester 0
- eng_en  out  1  engine enable
- eng_kernel  out  6*(QI+QF)  latched kernel
- eng_signal  out  2*(QI+QF)*NUM_ELEMS  latched signal
- eng_conv  in  2*(QI+QF)*(NUM_ELEMS+2)  engine result
- eng_overflow  in  1  engine overflow flag
- eng_done  in  1  engine completion
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_conv  out  2*(QI+QF)*(NUM_ELEMS+2)  captured result
- rsp_overflow  out  1  captured overflow
- rsp_timeout  out  1  job aborted by watchdog
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; `last_grant` is set to 1, so requester 0 wins first.
  - `eng_en`, `rsp_valid`, `rsp_id`, `rsp_overflow`, `rsp_timeout` and `busy` all reset to 0.
  - `eng_kernel`, `eng_signal` and `rsp_conv` reset to 0.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester is granted. If both are high, the requester != `last_grant` wins.
  - `reqN_ready` = (state==IDLE) & grant==N & reqN_valid; at most one ready is high per cycle.
  - On the accepting edge: latch the operands into `eng_kernel`/`eng_signal`, set `rsp_id` = N, set `last_grant` = N, set `eng_en` = 1, and go to RUN.
- RUN:
  - `eng_en` is held at 1 and the operands are held stable.
  - On the first edge with `eng_done`=1:
    - capture `eng_conv` into `rsp_conv` and `eng_overflow` into `rsp_overflow`;
    - set `eng_en` = 0 and `rsp_valid` = 1;
    - go to RESP.
  - Latency: `rsp_valid` is high the cycle after `eng_done` is sampled high.
- RESP:
  - `rsp_valid` = 1 and all `rsp_*` outputs are held stable until `rsp_valid` & `rsp_ready`.
  - On that edge: `rsp_valid` = 0, `rsp_timeout` = 0, go to IDLE.
  - No new request is accepted in the same cycle; minimum spacing between jobs is 1 IDLE cycle. This guarantees `eng_en` is low for ≥2 cycles between jobs, so the engine re-arms.
- `eng_done` is ignored outside RUN; a stale done seen in IDLE/RESP causes no capture.
- Requester inputs may change while not ready; only the values on the accepting edge are used.
- Reset mid-RUN or mid-RESP: `eng_en` drops immediately and the pending job and response are discarded.
- `busy` is high in RUN and RESP.

Optional Feature:
- Macro: CONV_TIMEOUT_EN.
- Defined:
  - A cycle counter, clog2(TIMEOUT_CYCLES+1) bits wide, clears on entry to RUN and increments each RUN cycle without `eng_done`.
  - When it reaches TIMEOUT_CYCLES: set `eng_en` = 0, `rsp_conv` = 0, `rsp_overflow` = 0, `rsp_timeout` = 1, `rsp_valid` = 1, and go to RESP.
  - If `eng_done` arrives in the same cycle as the timeout, done wins (normal capture, `rsp_timeout` = 0).
- Undefined: no counter; `rsp_timeout` is tied to 0; RUN waits indefinitely for `eng_done`.

Test Plan:
- Single job: req0_kernel=48'h04_20_12_F0_00_F4, req0_signal=48'h11_D0_FA_14_28_FC; engine model asserts done 5 cycles after en with conv=80'hA5..5A, ovf=1 -> `req0_ready` pulses 1 cycle; `eng_kernel`/`eng_signal` match the inputs; `rsp_valid` is high the cycle after done with `rsp_id`=0, `rsp_conv`=80'hA5..5A, `rsp_overflow`=1.
- Contention: req0_valid=req1_valid=1 held for 4 jobs -> grant order is 0,1,0,1; `rsp_id` sequence is 0,1,0,1; `eng_en` is low ≥2 cycles between jobs.
- Backpressure: `rsp_ready`=0 for 10 cycles -> `rsp_*` stay stable, no ready pulses, `busy`=1; `rsp_ready`=1 -> IDLE next cycle.
- Stale done: `eng_done`=1 while IDLE for 3 cycles -> `rsp_valid` stays 0, no capture.
- Reset mid-RUN: rst=0 two cycles after accept -> `eng_en`=0, `rsp_valid`=0, `busy`=0 immediately; the next req1 job completes normally.
- CONV_TIMEOUT_EN, TIMEOUT_CYCLES=8, engine never asserts done -> after 8 RUN cycles `rsp_valid`=1, `rsp_timeout`=1, `rsp_conv`=0; done and timeout in the same cycle -> normal result with `rsp_timeout`=0.
